// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: FSM state type, default PC width and the
// jump/branch target constants.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_W_DEFAULT = 10;

  // Target LUT contents. Each entry is an absolute target for Jump and a signed
  // offset for a taken branch, so they are kept as signed ints and truncated to PC_W.
  localparam int kTarg0 = 5;
  localparam int kTarg1 = -3;
  localparam int kTarg2 = 100;
  localparam int kTarg3 = 1020;

endpackage

// File: rtl/pc_target_lut.sv
// 4-entry jump/branch target lookup, purely combinational.
module pc_target_lut
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic [1:0]      PCTarg,
  output logic [PC_W-1:0] Target
);

  // Select the constant addressed by the decoder's target index.
  always_comb begin
    Target = '0;
    unique case (PCTarg)
      2'd0: Target = PC_W'(kTarg0);
      2'd1: Target = PC_W'(kTarg1);
      2'd2: Target = PC_W'(kTarg2);
      2'd3: Target = PC_W'(kTarg3);
      default: Target = '0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer for the 9-bit core. Runs the Start/Done
// handshake with the harness and resolves jumps and branches.
// Optional feature: define FETCH_STALL_EN to add the Stall input, which freezes
// the PC and the FSM while running.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     PC_W       = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Jump,
  input  logic            BranchEn,
  input  logic            Zero,
  input  logic [1:0]      PCTarg,
  input  logic            Ack,
`ifdef FETCH_STALL_EN
  input  logic            Stall,
`endif
  output logic [PC_W-1:0] ProgCtr,
  output logic            Running,
  output logic            Done
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] target;
  logic            stall;

`ifdef FETCH_STALL_EN
  assign stall = Stall;
`else
  assign stall = 1'b0;
`endif

  pc_target_lut #(
    .PC_W(PC_W)
  ) u_lut (
    .PCTarg(PCTarg),
    .Target(target)
  );

  // Next state and next PC; in RUN the priority is Ack > Jump > taken branch > increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        pc_d = '0;
        if (Start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
        end
      end
      RUN: begin
        if (!stall) begin
          if (Ack) begin
            // PC stays on the halt instruction.
            state_d = DONE;
          end else if (Jump) begin
            pc_d = target;
          end else if (BranchEn && Zero) begin
            // Offset is PC_W wide, so the sum is already sign-extended and wraps mod 2**PC_W.
            pc_d = pc_q + target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      DONE: begin
        if (!Start) begin
          state_d = IDLE;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // State and PC registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign ProgCtr = pc_q;
  assign Running = (state_q == RUN);
  assign Done    = (state_q == DONE);

endmodule
